// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter
// Shares the single frame-buffer read port between the display scanner
// (strict priority) and the gesture/aspect-ratio analyzer (served in gaps).
// Every issued read carries a {valid, owner} tag down a fixed-length
// pipeline, so the pixel returned RD_LAT cycles later is steered to the
// requester that issued it, in issue order.
//
// Owner states (registered, also driven on 'owner'):
//   state     | meaning
//   ----------+------------------------------------------------------
//   OWN_IDLE  | no read issued on the last edge, fb_en low
//   OWN_DISP  | display read issued on the last edge
//   OWN_ANA   | analyzer read issued on the last edge

module fb_read_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk25,
  input  logic              rst_n,

  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,

  input  logic              ana_req,
  input  logic [ADDR_W-1:0] ana_addr,
  output logic              ana_gnt,
  output logic [DATA_W-1:0] ana_data,
  output logic              ana_valid,
  output logic              ana_starved,

  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_en,
  input  logic [DATA_W-1:0] frame_pixel,

  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_DISP = 2'b01,
    OWN_ANA  = 2'b10
  } owner_t;

  localparam int         CNT_W     = 10;
  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] STARVE_TH = 10'(STARVE_MAX);

  owner_t             state;

  // Tag pipeline: index 0 is written on the issue edge, index RD_LAT is
  // consumed on the edge where the matching pixel is on frame_pixel.
  logic [RD_LAT:0]    tag_v;
  logic [RD_LAT:0]    tag_ana;
  logic               push_v;
  logic               push_ana;

  logic [CNT_W-1:0]   starve_cnt;
  logic [CNT_W-1:0]   starve_next;

  // Display always wins; the analyzer only gets the port in display gaps.
  // Only ana_req is qualified by disp_req, so garbage on the analyzer
  // inputs can never reach the display path while the display is reading.
  assign ana_gnt  = ana_req & ~disp_req;
  assign push_v   = disp_req | ana_gnt;
  assign push_ana = ana_gnt;

  assign owner = state;

  // Owner FSM: capture the winning address and enable on every edge.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OWN_IDLE;
      fb_addr <= '0;
      fb_en   <= 1'b0;
    end else begin
      if (disp_req) begin
        state   <= OWN_DISP;
        fb_addr <= disp_addr;
        fb_en   <= 1'b1;
      end else if (ana_req) begin
        state   <= OWN_ANA;
        fb_addr <= ana_addr;
        fb_en   <= 1'b1;
      end else begin
        // fb_addr deliberately holds so the RAM address bus stays quiet.
        state   <= OWN_IDLE;
        fb_en   <= 1'b0;
      end
    end
  end

  // Tag shift register: never stalls, one entry per edge.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      tag_v   <= '0;
      tag_ana <= '0;
    end else begin
      tag_v   <= {tag_v[RD_LAT-1:0], push_v};
      tag_ana <= {tag_ana[RD_LAT-1:0], push_ana};
    end
  end

  // Return path: steer the sampled pixel to the owner of the exiting tag.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
      ana_data   <= '0;
      ana_valid  <= 1'b0;
    end else begin
      disp_valid <= tag_v[RD_LAT] & ~tag_ana[RD_LAT];
      ana_valid  <= tag_v[RD_LAT] &  tag_ana[RD_LAT];
      if (tag_v[RD_LAT] && !tag_ana[RD_LAT]) begin
        disp_data <= frame_pixel;
      end
      if (tag_v[RD_LAT] && tag_ana[RD_LAT]) begin
        ana_data <= frame_pixel;
      end
    end
  end

  // Next starvation count: saturating run length of denied request cycles.
  always_comb begin
    starve_next = '0;
    if (ana_req && !ana_gnt) begin
      starve_next = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 10'd1;
    end
  end

  // Starvation counter and flag; the flag tracks the updated count so it
  // rises on the edge of the STARVE_MAX-th denial and drops on the grant edge.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt  <= '0;
      ana_starved <= 1'b0;
    end else begin
      starve_cnt  <= starve_next;
      ana_starved <= (starve_next >= STARVE_TH);
    end
  end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Bench for fb_read_arbiter: two instances (RD_LAT=1/STARVE_MAX=4 and
// RD_LAT=3/STARVE_MAX=64) share one stimulus stream. A frame-buffer model
// per instance returns pix_of(address). The reference model schedules each
// read's expected return in a cycle-indexed table and tracks owner,
// address, and denied-run length directly from the arbitration rules.

module tb_fb_read_arbiter;

  localparam int AW = 17;
  localparam int DW = 16;

  logic          clk25 = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req = 1'b0;
  logic          ana_req  = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [AW-1:0] ana_addr  = '0;

  logic [DW-1:0] d_data[2];
  logic [DW-1:0] a_data[2];
  logic [DW-1:0] f_pix[2];
  logic          d_valid[2];
  logic          a_valid[2];
  logic          a_gnt[2];
  logic          a_starved[2];
  logic          f_en[2];
  logic [AW-1:0] f_addr[2];
  logic [1:0]    own[2];

  int checks = 0;
  int errors = 0;

  always #20 clk25 = ~clk25;

  fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4)) u_lat1 (
    .clk25(clk25), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(d_data[0]), .disp_valid(d_valid[0]),
    .ana_req(ana_req), .ana_addr(ana_addr), .ana_gnt(a_gnt[0]), .ana_data(a_data[0]),
    .ana_valid(a_valid[0]), .ana_starved(a_starved[0]),
    .fb_addr(f_addr[0]), .fb_en(f_en[0]), .frame_pixel(f_pix[0]), .owner(own[0])
  );

  fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(64)) u_lat3 (
    .clk25(clk25), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(d_data[1]), .disp_valid(d_valid[1]),
    .ana_req(ana_req), .ana_addr(ana_addr), .ana_gnt(a_gnt[1]), .ana_data(a_data[1]),
    .ana_valid(a_valid[1]), .ana_starved(a_starved[1]),
    .fb_addr(f_addr[1]), .fb_en(f_en[1]), .frame_pixel(f_pix[1]), .owner(own[1])
  );

  function automatic logic [DW-1:0] pix_of(input logic [AW-1:0] a);
    return a[15:0] ^ {a[16], 15'd0};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int sth_of(input int i);
    return (i == 0) ? 4 : 64;
  endfunction

  // Frame-buffer models: synchronous RAM with 1 and 3 cycles of latency.
  logic [DW-1:0] fb0 = '0;
  logic [DW-1:0] fb1_s[3];
  always @(posedge clk25) begin
    if (f_en[0]) fb0 <= pix_of(f_addr[0]);
  end
  always @(posedge clk25) begin
    if (f_en[1]) fb1_s[0] <= pix_of(f_addr[1]);
    fb1_s[1] <= fb1_s[0];
    fb1_s[2] <= fb1_s[1];
  end
  assign f_pix[0] = fb0;
  assign f_pix[1] = fb1_s[2];

  // Reference model state
  int            cyc = 0;
  bit            sv[2][8];
  bit            sa[2][8];
  logic [DW-1:0] sp[2][8];
  logic [DW-1:0] m_dd[2];
  logic [DW-1:0] m_ad[2];
  logic [AW-1:0] m_fa[2];
  logic          m_en[2];
  logic [1:0]    m_own[2];
  int            m_cnt[2];

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 8; s++) begin
        sv[i][s] = 1'b0;
        sa[i][s] = 1'b0;
        sp[i][s] = '0;
      end
      m_dd[i]  = '0;
      m_ad[i]  = '0;
      m_fa[i]  = '0;
      m_en[i]  = 1'b0;
      m_own[i] = 2'b00;
      m_cnt[i] = 0;
    end
  endtask

  // One clock: drive inputs at the falling edge, check the grant, then check
  // everything the rising edge produced against the model.
  task automatic tick(input logic dr, input logic [AW-1:0] da, input logic ar, input logic [AW-1:0] aa);
    @(negedge clk25);
    disp_req  = dr;
    disp_addr = da;
    ana_req   = ar;
    ana_addr  = aa;
    #1;
    for (int i = 0; i < 2; i++) chk("ana_gnt", i, a_gnt[i], ar & ~dr);
    @(posedge clk25);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      int cs;
      int ns;
      logic ev_d;
      logic ev_a;
      cs   = cyc % 8;
      ns   = (cyc + lat_of(i) + 1) % 8;
      ev_d = sv[i][cs] & ~sa[i][cs];
      ev_a = sv[i][cs] & sa[i][cs];
      if (ev_d) m_dd[i] = sp[i][cs];
      if (ev_a) m_ad[i] = sp[i][cs];
      sv[i][cs] = 1'b0;
      if (dr) begin
        sv[i][ns] = 1'b1; sa[i][ns] = 1'b0; sp[i][ns] = pix_of(da);
        m_own[i] = 2'b01; m_fa[i] = da; m_en[i] = 1'b1;
      end else if (ar) begin
        sv[i][ns] = 1'b1; sa[i][ns] = 1'b1; sp[i][ns] = pix_of(aa);
        m_own[i] = 2'b10; m_fa[i] = aa; m_en[i] = 1'b1;
      end else begin
        sv[i][ns] = 1'b0;
        m_own[i] = 2'b00; m_en[i] = 1'b0;
      end
      if (ar && dr) m_cnt[i] = (m_cnt[i] >= 1023) ? 1023 : m_cnt[i] + 1;
      else          m_cnt[i] = 0;
      chk("disp_valid",  i, d_valid[i],   ev_d);
      chk("disp_data",   i, d_data[i],    m_dd[i]);
      chk("ana_valid",   i, a_valid[i],   ev_a);
      chk("ana_data",    i, a_data[i],    m_ad[i]);
      chk("owner",       i, own[i],       m_own[i]);
      chk("fb_en",       i, f_en[i],      m_en[i]);
      chk("fb_addr",     i, f_addr[i],    m_fa[i]);
      chk("ana_starved", i, a_starved[i], m_cnt[i] >= sth_of(i));
    end
  endtask

  // Asynchronous reset at mid-cycle; outputs must clear without a clock.
  task automatic do_reset(input int hold);
    @(negedge clk25);
    rst_n    = 1'b0;
    disp_req = 1'b0;
    ana_req  = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_fb_addr",     i, f_addr[i],    0);
      chk("rst_fb_en",       i, f_en[i],      0);
      chk("rst_owner",       i, own[i],       0);
      chk("rst_disp_valid",  i, d_valid[i],   0);
      chk("rst_disp_data",   i, d_data[i],    0);
      chk("rst_ana_valid",   i, a_valid[i],   0);
      chk("rst_ana_data",    i, a_data[i],    0);
      chk("rst_ana_starved", i, a_starved[i], 0);
    end
    repeat (hold) @(posedge clk25);
    model_reset();
    @(negedge clk25);
    rst_n = 1'b1;
  endtask

  logic          r_dr;
  logic          r_ar;
  logic [AW-1:0] r_da;
  logic [AW-1:0] r_aa;

  initial begin
    model_reset();
    do_reset(3);

    // Idle after reset
    repeat (20) tick(1'b0, '0, 1'b0, '0);

    // Back-to-back display reads 100..103
    for (int a = 100; a <= 103; a++) tick(1'b1, AW'(a), 1'b0, '0);
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    // Contention: display wins for 5 cycles while the analyzer address
    // wanders, then the analyzer is granted with its final address.
    for (int k = 0; k < 5; k++) tick(1'b1, AW'(200 + k), 1'b1, AW'(700 + k));
    tick(1'b0, '0, 1'b1, AW'(705));
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    // Starvation for 10 denied cycles, then grant
    for (int k = 0; k < 10; k++) tick(1'b1, AW'(300 + k), 1'b1, AW'(17'h1_2345));
    tick(1'b0, '0, 1'b1, AW'(17'h1_2345));
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    // Longer denial crossing the 64 threshold, then withdrawal before grant
    for (int k = 0; k < 70; k++) tick(1'b1, AW'(1000 + k), 1'b1, AW'(900));
    tick(1'b0, '0, 1'b0, '0);
    tick(1'b0, '0, 1'b1, AW'(901));
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    // Interleaved display/analyzer issue
    tick(1'b1, AW'(10), 1'b0, '0);
    tick(1'b0, '0, 1'b1, AW'(500));
    tick(1'b1, AW'(11), 1'b0, '0);
    tick(1'b0, '0, 1'b1, AW'(501));
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    // Reset with two reads in flight, then a fresh read
    tick(1'b1, AW'(20), 1'b0, '0);
    tick(1'b0, '0, 1'b1, AW'(600));
    do_reset(2);
    repeat (6) tick(1'b0, '0, 1'b0, '0);
    tick(1'b1, AW'(30), 1'b0, '0);
    tick(1'b0, '0, 1'b1, AW'(601));
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    // Denial long enough to hit counter saturation
    for (int k = 0; k < 1030; k++) tick(1'b1, AW'(k), 1'b1, AW'(17'h1_0F0F));
    tick(1'b0, '0, 1'b1, AW'(17'h1_0F0F));
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    // Randomized traffic; analyzer mostly holds its address while waiting
    r_ar = 1'b0;
    r_aa = '0;
    for (int n = 0; n < 400; n++) begin
      r_dr = ($urandom_range(0, 9) < 5);
      r_da = AW'($urandom_range(0, 131071));
      if (!r_ar || ($urandom_range(0, 9) == 0)) begin
        r_ar = ($urandom_range(0, 9) < 6);
        r_aa = AW'($urandom_range(0, 131071));
      end
      tick(r_dr, r_da, r_ar, r_aa);
      if (r_ar && !r_dr) r_ar = 1'b0;
    end
    repeat (6) tick(1'b0, '0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
